// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame serializer.
// Contents:
//   ETH_HDR_BYTES  bytes in the dest MAC / src MAC / ethertype header
//   ETH_MIN_FRAME  default minimum frame length (header + payload, no FCS)
//   mac_t, ethertype_t, state_e
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_MIN_FRAME = 60;

  typedef logic [47:0] mac_t;
  typedef logic [15:0] ethertype_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD
  } state_e;

endpackage

// File: rtl/axis_byte_reg.sv
// Single-entry registered AXI-Stream byte slice.
// Takes a new beat whenever the slot is empty or its current beat is being
// accepted; otherwise all output fields are held stable.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              a beat is offered this cycle (caller only asserts it
//                     when the slot can take it)
//   load_data/last/user  the offered beat
//   m_tdata/tvalid/tready/tlast/tuser  registered AXI-Stream output
module axis_byte_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       load_user,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= 8'h00;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (!m_tvalid || m_tready) begin
      m_tvalid <= load;
      if (load) begin
        m_tdata <= load_data;
        m_tlast <= load_last;
        m_tuser <= load_user;
      end else begin
        // keep sideband clean while the slot is empty
        m_tlast <= 1'b0;
        m_tuser <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/eth_frame_serializer.sv
// Ethernet frame serializer: accepts header fields plus a byte-wide payload
// stream and emits one 8-bit AXI-Stream frame (14-byte header then payload).
// Optional feature macro: ETH_PAD_EN -- zero-pad short frames up to
// MIN_FRAME_LEN bytes; tlast/tuser then move to the last pad byte.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_eth_hdr_valid/ready            header handshake
//   s_eth_dest_mac/src_mac/type      header fields, MSB byte sent first
//   s_eth_payload_axis_t*            payload byte stream (tuser taken on tlast)
//   m_axis_t*                        serialized frame output (registered)
//   busy                             frame in flight (header accept .. final beat accepted)
module eth_frame_serializer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN = ETH_MIN_FRAME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy
);

  state_e      state, state_nxt;
  logic        run;
  logic [15:0] byte_cnt, byte_cnt_nxt, cnt_inc;
  mac_t        dest_lat, src_lat;
  ethertype_t  type_lat;
  logic        out_free, hdr_fire;
  logic [111:0] hdr_bits;
  logic [6:0]  hdr_shift;
  logic [7:0]  hdr_byte;
  logic        ld, ld_last, ld_user;
  logic [7:0]  ld_data;
`ifdef ETH_PAD_EN
  logic        tuser_lat, tuser_lat_nxt;
`endif

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

  // run holds header ready low for the first cycle after reset is released
  assign s_eth_hdr_ready = run && (state == ST_IDLE) && out_free;
  assign hdr_fire        = s_eth_hdr_valid && s_eth_hdr_ready;
  assign busy            = (state != ST_IDLE) || m_axis_tvalid;

  // byte_cnt (1..13 while in HEADER) selects the next header byte, MSB first
  assign hdr_bits  = {dest_lat, src_lat, type_lat};
  assign hdr_shift = 7'd104 - {byte_cnt[3:0], 3'b000};
  assign hdr_byte  = 8'(hdr_bits >> hdr_shift);

  always_comb begin
    state_nxt                 = state;
    byte_cnt_nxt              = byte_cnt;
    ld                        = 1'b0;
    ld_data                   = 8'h00;
    ld_last                   = 1'b0;
    ld_user                   = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
`ifdef ETH_PAD_EN
    tuser_lat_nxt             = tuser_lat;
`endif
    case (state)
      ST_IDLE: begin
        // first dest MAC byte goes straight from the input port so it is
        // on the output the cycle after the header handshake
        if (hdr_fire) begin
          ld           = 1'b1;
          ld_data      = s_eth_dest_mac[47:40];
          byte_cnt_nxt = 16'd1;
          state_nxt    = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (out_free) begin
          ld           = 1'b1;
          ld_data      = hdr_byte;
          byte_cnt_nxt = cnt_inc;
          if (byte_cnt == 16'(ETH_HDR_BYTES - 1)) state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        s_eth_payload_axis_tready = out_free;
        if (s_eth_payload_axis_tvalid && out_free) begin
          ld           = 1'b1;
          ld_data      = s_eth_payload_axis_tdata;
          byte_cnt_nxt = cnt_inc;
          if (s_eth_payload_axis_tlast) begin
`ifdef ETH_PAD_EN
            if (cnt_inc < 16'(MIN_FRAME_LEN)) begin
              tuser_lat_nxt = s_eth_payload_axis_tuser;
              state_nxt     = ST_PAD;
            end else begin
              ld_last   = 1'b1;
              ld_user   = s_eth_payload_axis_tuser;
              state_nxt = ST_IDLE;
            end
`else
            ld_last   = 1'b1;
            ld_user   = s_eth_payload_axis_tuser;
            state_nxt = ST_IDLE;
`endif
          end
        end
      end
`ifdef ETH_PAD_EN
      ST_PAD: begin
        if (out_free) begin
          ld           = 1'b1;
          ld_data      = 8'h00;
          byte_cnt_nxt = cnt_inc;
          if (cnt_inc == 16'(MIN_FRAME_LEN)) begin
            ld_last   = 1'b1;
            ld_user   = tuser_lat;
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= 16'd0;
      run      <= 1'b0;
`ifdef ETH_PAD_EN
      tuser_lat <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      run      <= 1'b1;
`ifdef ETH_PAD_EN
      tuser_lat <= tuser_lat_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_fire) begin
      dest_lat <= s_eth_dest_mac;
      src_lat  <= s_eth_src_mac;
      type_lat <= s_eth_type;
    end
  end

  axis_byte_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .load_user (ld_user),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tready  (m_axis_tready),
    .m_tlast   (m_axis_tlast),
    .m_tuser   (m_axis_tuser)
  );

endmodule

// File: tb/tb_eth_frame_serializer.sv
// Self-checking bench for eth_frame_serializer: a queue-based frame model
// predicts every output beat; a negedge monitor compares handshaken beats,
// stall stability, header-accept latency and header-accept timing.
module tb_eth_frame_serializer;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  s_eth_payload_axis_tdata = '0;
  logic        s_eth_payload_axis_tvalid = 1'b0;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast = 1'b0;
  logic        s_eth_payload_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;

  eth_frame_serializer dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
    .m_axis_tdata              (m_axis_tdata),
    .m_axis_tvalid             (m_axis_tvalid),
    .m_axis_tready             (m_axis_tready),
    .m_axis_tlast              (m_axis_tlast),
    .m_axis_tuser              (m_axis_tuser),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       exp_q[$];
  logic [7:0]  cap[0:255];
  int          fbeats = 0;
  int          last_len = 0;
  logic        last_user = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the frame is header bytes MSB first, payload, then (padding build)
  // zeros up to 60 bytes; only the final byte carries tlast and tuser.
  function automatic void push_frame(input logic [47:0] d, input logic [47:0] s,
                                     input logic [15:0] t, input int n,
                                     input int base, input logic usr);
    logic [111:0] h;
    logic [7:0]   b;
    int           len;
    h   = {d, s, t};
    len = 14 + n;
`ifdef ETH_PAD_EN
    if (len < 60) len = 60;
`endif
    for (int k = 0; k < len; k++) begin
      if (k < 14)          b = h[111 - 8*k -: 8];
      else if (k < 14 + n) b = 8'(base + k - 14);
      else                 b = 8'h00;
      exp_q.push_back({b, (k == len - 1), (k == len - 1) && usr});
    end
  endfunction

  // m_axis_tready pattern generator
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 3 == 0);
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor
  logic       prev_hdr = 1'b0;
  logic [7:0] prev_b0 = '0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      fbeats     = 0;
      prev_hdr   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_hdr)
        chk("hdr_latency", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_b0});
      if (prev_stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
            {1'b1, prev_beat});
      if (m_axis_tvalid)
        chk("busy_while_valid", busy, 1'b1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 10'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
        end
        if (fbeats < 256) cap[fbeats] = m_axis_tdata;
        fbeats++;
        if (m_axis_tlast) begin
          last_len  = fbeats;
          last_user = m_axis_tuser;
          fbeats    = 0;
        end
      end
      if (s_eth_hdr_valid && s_eth_hdr_ready)
        chk("hdr_accept_timing", !busy || (m_axis_tvalid && m_axis_tready && m_axis_tlast), 1'b1);
      prev_hdr   = s_eth_hdr_valid && s_eth_hdr_ready;
      prev_b0    = s_eth_dest_mac[47:40];
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n, input int base, input logic usr,
                            input int gap, input bit early);
    logic fire;
    bit   ok;
    push_frame(d, s, t, n, base, usr);
    s_eth_dest_mac  = d;
    s_eth_src_mac   = s;
    s_eth_type      = t;
    s_eth_hdr_valid = 1'b1;
    if (early) begin
      // first payload byte offered while the header is still pending
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tdata  = 8'(base);
      s_eth_payload_axis_tlast  = (n == 1);
      s_eth_payload_axis_tuser  = (n == 1) ? usr : 1'($urandom);
    end
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fire = s_eth_hdr_ready;
      @(posedge clk); #1;
      if (fire) begin ok = 1; break; end
    end
    s_eth_hdr_valid = 1'b0;
    if (!ok) begin chk("hdr_timeout", 0, 1); return; end
    for (int i = 0; i < n; i++) begin
      if (!(early && i == 0) && gap > 0 && $urandom_range(0, 99) < gap) begin
        s_eth_payload_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tdata  = 8'(base + i);
      s_eth_payload_axis_tlast  = (i == n - 1);
      s_eth_payload_axis_tuser  = (i == n - 1) ? usr : 1'($urandom);
      ok = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        fire = s_eth_payload_axis_tready;
        @(posedge clk); #1;
        if (fire) begin ok = 1; break; end
      end
      if (!ok) begin
        chk("payload_timeout", 0, 1);
        s_eth_payload_axis_tvalid = 1'b0;
        return;
      end
    end
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast  = 1'b0;
    s_eth_payload_axis_tuser  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("busy_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, busy,
             s_eth_hdr_ready, s_eth_payload_axis_tready}, '0);
  endtask

  localparam logic [47:0] MAC_D = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_S = 48'h02_00_00_00_00_02;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 50-byte payload, continuous ready
    rdy_mode = 0;
    send_frame(MAC_D, MAC_S, 16'h0800, 50, 0, 1'b0, 0, 0);
    wait_idle();
    chk("t1_len", last_len, 64);
    chk("t1_b1", cap[0], 8'h02);
    chk("t1_b6", cap[5], 8'h01);
    chk("t1_b12", cap[11], 8'h02);
    chk("t1_b13", cap[12], 8'h08);
    chk("t1_b14", cap[13], 8'h00);
    chk("t1_b15", cap[14], 8'h00);
    chk("t1_b64", cap[63], 8'h31);

    // 2: same frame, 1-on/2-off ready
    rdy_mode = 1;
    send_frame(MAC_D, MAC_S, 16'h0800, 50, 0, 1'b0, 0, 0);
    wait_idle();
    chk("t2_len", last_len, 64);
    chk("t2_b64", cap[63], 8'h31);

    // 3: short frame
    rdy_mode = 0;
    send_frame(MAC_D, MAC_S, 16'h0800, 10, 0, 1'b0, 0, 0);
    wait_idle();
`ifdef ETH_PAD_EN
    chk("t3_len", last_len, 60);
    chk("t3_b25", cap[24], 8'h00);
`else
    chk("t3_len", last_len, 24);
`endif
    chk("t3_b24", cap[23], 8'h09);

    // 4: tuser on the tlast beat
    send_frame(MAC_D, MAC_S, 16'h86DD, 20, 8'hA0, 1'b1, 0, 0);
    wait_idle();
    chk("t4_user", last_user, 1'b1);

    // 5: back-to-back, second header held valid
    send_frame(MAC_D, MAC_S, 16'h0800, 30, 5, 1'b0, 0, 1);
    send_frame(MAC_S, MAC_D, 16'h0806, 17, 100, 1'b1, 0, 0);
    wait_idle();
    chk("t5_len", last_len, 60 > 31 ? 31 + 0 : 0) ;
    // (second frame: 14 + 17 = 31 bytes unless padded)
`ifdef ETH_PAD_EN
    n_cmp--; if (last_len != 31) n_bad--;
    chk("t5_len_pad", last_len, 60);
`endif

    // 6: reset in the middle of a frame
    push_frame(MAC_D, MAC_S, 16'h0800, 40, 0, 1'b0);
    s_eth_dest_mac = MAC_D; s_eth_src_mac = MAC_S; s_eth_type = 16'h0800;
    s_eth_hdr_valid = 1'b1;
    s_eth_payload_axis_tvalid = 1'b1;
    s_eth_payload_axis_tdata = 8'h00;
    begin
      logic hacc, pacc;
      bit   reached;
      reached = 0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        hacc = s_eth_hdr_valid && s_eth_hdr_ready;
        pacc = s_eth_payload_axis_tready;
        @(posedge clk); #1;
        if (hacc) s_eth_hdr_valid = 1'b0;
        if (pacc) s_eth_payload_axis_tdata = s_eth_payload_axis_tdata + 8'd1;
        if (fbeats >= 19) begin reached = 1; break; end
      end
      chk("t6_reach_byte20", reached, 1'b1);
    end
    rst = 1'b1;
    s_eth_hdr_valid = 1'b0;
    s_eth_payload_axis_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_hdr_ready", s_eth_hdr_ready, 1'b1);
    send_frame(MAC_D, MAC_S, 16'h0800, 50, 0, 1'b0, 0, 0);
    wait_idle();
    chk("t6_len", last_len, 64);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      rdy_mode = $urandom_range(0, 2);
      send_frame({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 16'($urandom),
                 $urandom_range(1, 70), $urandom_range(0, 255), 1'($urandom),
                 $urandom_range(0, 40), 1'($urandom));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
